// File: rtl/tx_train_pkg.sv
// Shared constants and types for the TX packet-train scheduler.
package tx_train_pkg;

  localparam int unsigned DefCntWidth   = 32;
  localparam int unsigned TrainCntWidth = 16;

  localparam logic [2:0] EncIdle      = 3'd0;
  localparam logic [2:0] EncPass      = 3'd1;
  localparam logic [2:0] EncPktGap    = 3'd2;
  localparam logic [2:0] EncTrainGap  = 3'd3;
  localparam logic [2:0] EncDrain     = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = EncIdle,
    StPass     = EncPass,
    StPktGap   = EncPktGap,
    StTrainGap = EncTrainGap,
    StDrain    = EncDrain
  } state_e;

  typedef logic [TrainCntWidth-1:0] train_cnt_t;

  // A zero-length train would never complete, so it behaves as a single packet.
  function automatic train_cnt_t eff_train_len(input train_cnt_t len);
    return (len == '0) ? train_cnt_t'(1) : len;
  endfunction

endpackage

// File: rtl/tx_train_gap_timer.sv
// Idle-gap down-counter shared by the packet-gap and train-gap states.
module tx_train_gap_timer #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 expired
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntOne;
    end
  end

  // Flags the last idle cycle, so the gap state leaves after exactly load_val cycles.
  assign expired = (cnt_q <= CntOne);

endmodule

// File: rtl/tx_train_scheduler.sv
// Paces an AXI4-Stream packet flow into trains with programmable packet and train gaps.
module tx_train_scheduler
  import tx_train_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH      = DefCntWidth
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic                        start,
  input  logic                        stop,
  input  logic [TrainCntWidth-1:0]    cfg_train_len,
  input  logic [TrainCntWidth-1:0]    cfg_num_trains,
  input  logic [CNT_WIDTH-1:0]        cfg_pkt_gap,
  input  logic [CNT_WIDTH-1:0]        cfg_train_gap,

  input  logic [AXI_DATA_WIDTH-1:0]   s_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_tstrb,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,

  output logic [AXI_DATA_WIDTH-1:0]   m_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_tstrb,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,

  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        pkts_sent,
  output logic [TrainCntWidth-1:0]    trains_sent
);

  localparam logic [CNT_WIDTH-1:0]     CntOne   = CNT_WIDTH'(1);
  localparam logic [TrainCntWidth-1:0] TrainOne = TrainCntWidth'(1);

  state_e                   state_q, state_d;
  logic                     done_q, done_d;
  logic                     in_pkt_q, in_pkt_d;
  logic [CNT_WIDTH-1:0]     pkts_sent_q, pkts_sent_d;
  logic [TrainCntWidth-1:0] trains_sent_q, trains_sent_d;
  logic [TrainCntWidth-1:0] train_pkts_q, train_pkts_d;

  // Run configuration captured at start.
  logic [TrainCntWidth-1:0] train_len_q, train_len_d;
  logic [TrainCntWidth-1:0] num_trains_q, num_trains_d;
  logic [CNT_WIDTH-1:0]     pkt_gap_q, pkt_gap_d;
  logic [CNT_WIDTH-1:0]     train_gap_q, train_gap_d;

  logic                     gate;
  logic                     accept;
  logic                     end_beat;
  logic [TrainCntWidth-1:0] train_pkts_inc;
  logic [TrainCntWidth-1:0] trains_inc;
  logic                     train_done;
  logic                     final_train;

  logic                     gap_load;
  logic                     gap_en;
  logic [CNT_WIDTH-1:0]     gap_load_val;
  logic                     gap_expired;

  // Stream path: data is never touched, only valid/ready are gated.
  assign gate     = (state_q == StPass) || (state_q == StDrain);
  assign m_tdata  = s_tdata;
  assign m_tstrb  = s_tstrb;
  assign m_tlast  = s_tlast;
  assign m_tvalid = s_tvalid & gate;
  assign s_tready = m_tready & gate;

  assign accept   = m_tvalid & m_tready;
  assign end_beat = accept & s_tlast;

  assign train_pkts_inc = train_pkts_q + TrainOne;
  assign trains_inc     = trains_sent_q + TrainOne;
  assign train_done     = (train_pkts_inc == train_len_q);
  assign final_train    = train_done && (num_trains_q != '0) && (trains_inc == num_trains_q);

  assign gap_en = (state_q == StPktGap) || (state_q == StTrainGap);

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    in_pkt_d      = in_pkt_q;
    pkts_sent_d   = pkts_sent_q;
    trains_sent_d = trains_sent_q;
    train_pkts_d  = train_pkts_q;
    train_len_d   = train_len_q;
    num_trains_d  = num_trains_q;
    pkt_gap_d     = pkt_gap_q;
    train_gap_d   = train_gap_q;
    gap_load      = 1'b0;
    gap_load_val  = pkt_gap_q;

    if (accept) begin
      in_pkt_d = ~s_tlast;
    end

    // Completed packets are counted identically in PASS and DRAIN.
    if (end_beat) begin
      pkts_sent_d = pkts_sent_q + CntOne;
      if (train_done) begin
        trains_sent_d = trains_inc;
        train_pkts_d  = '0;
      end else begin
        train_pkts_d = train_pkts_inc;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          train_len_d   = eff_train_len(cfg_train_len);
          num_trains_d  = cfg_num_trains;
          pkt_gap_d     = cfg_pkt_gap;
          train_gap_d   = cfg_train_gap;
          pkts_sent_d   = '0;
          trains_sent_d = '0;
          train_pkts_d  = '0;
          in_pkt_d      = 1'b0;
          state_d       = StPass;
        end
      end

      StPass: begin
        if (stop) begin
          // A presented but unaccepted beat must not be withdrawn, so it drains too.
          if (end_beat) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (in_pkt_q || s_tvalid) begin
            state_d = StDrain;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (end_beat) begin
          if (final_train) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (train_done) begin
            if (train_gap_q != '0) begin
              state_d      = StTrainGap;
              gap_load     = 1'b1;
              gap_load_val = train_gap_q;
            end
          end else if (pkt_gap_q != '0) begin
            state_d  = StPktGap;
            gap_load = 1'b1;
          end
        end
      end

      StPktGap, StTrainGap: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (gap_expired) begin
          state_d = StPass;
        end
      end

      StDrain: begin
        if (end_beat) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      done_q        <= 1'b0;
      in_pkt_q      <= 1'b0;
      pkts_sent_q   <= '0;
      trains_sent_q <= '0;
      train_pkts_q  <= '0;
      train_len_q   <= TrainOne;
      num_trains_q  <= '0;
      pkt_gap_q     <= '0;
      train_gap_q   <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      in_pkt_q      <= in_pkt_d;
      pkts_sent_q   <= pkts_sent_d;
      trains_sent_q <= trains_sent_d;
      train_pkts_q  <= train_pkts_d;
      train_len_q   <= train_len_d;
      num_trains_q  <= num_trains_d;
      pkt_gap_q     <= pkt_gap_d;
      train_gap_q   <= train_gap_d;
    end
  end

  tx_train_gap_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_gap_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (gap_load_val),
    .expired  (gap_expired)
  );

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign pkts_sent   = pkts_sent_q;
  assign trains_sent = trains_sent_q;

endmodule

// File: tb/tb_tx_train_scheduler.sv
// Directed bench for tx_train_scheduler: gap timing, counts, stop/drain, reset and config latching.
module tb_tx_train_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_train_len = '0;
  logic [15:0] cfg_num_trains = '0;
  logic [31:0] cfg_pkt_gap = '0;
  logic [31:0] cfg_train_gap = '0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tstrb = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;
  logic [15:0] trains_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int seq = 0;
  int start_cyc = 0;
  int last_end = 0;
  bit await_open = 1'b0;
  logic [63:0] rx_q[$];
  int rx_cyc_q[$];
  int gap_q[$];

  tx_train_scheduler #(
    .AXI_DATA_WIDTH (64),
    .CNT_WIDTH      (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .cfg_train_len  (cfg_train_len),
    .cfg_num_trains (cfg_num_trains),
    .cfg_pkt_gap    (cfg_pkt_gap),
    .cfg_train_gap  (cfg_train_gap),
    .s_tdata        (s_tdata),
    .s_tstrb        (s_tstrb),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .m_tdata        (m_tdata),
    .m_tstrb        (m_tstrb),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .busy           (busy),
    .done           (done),
    .pkts_sent      (pkts_sent),
    .trains_sent    (trains_sent)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observes accepted beats, done pulses and the idle length after each end beat.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (await_open && m_tvalid) begin
      gap_q.push_back(cyc - last_end - 1);
      await_open = 1'b0;
    end
    if (m_tvalid && m_tready) begin
      rx_q.push_back(m_tdata);
      rx_cyc_q.push_back(cyc);
      if (m_tlast) begin
        last_end   = cyc;
        await_open = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    gap_q.delete();
    await_open = 1'b0;
  endtask

  task automatic pulse_start(input int len, input int num, input int pg, input int tg);
    cfg_train_len  = 16'(len);
    cfg_num_trains = 16'(num);
    cfg_pkt_gap    = 32'(pg);
    cfg_train_gap  = 32'(tg);
    start          = 1'b1;
    start_cyc      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drives one packet; stop is raised while beat stop_beat is presented.
  task automatic send_pkt(input int beats, input int stop_beat, input bit rnd);
    int guard;
    bit acc;
    for (int b = 0; b < beats; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = 64'(seq);
      s_tstrb  = '1;
      s_tlast  = (b == beats - 1);
      if (b == stop_beat) stop = 1'b1;
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = m_tvalid && m_tready;
        @(posedge clk);
        #1;
        stop  = 1'b0;
        start = 1'b0;
        if (rnd) m_tready = 1'($urandom_range(0, 1));
        guard++;
      end
      if (!acc) begin
        check("beat_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
      seq++;
    end
  endtask

  task automatic send_pkts(input int n, input int beats, input bit rnd);
    for (int p = 0; p < n; p++) send_pkt(beats, -1, rnd);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int d0;
    int bad;

    // Reset state, with upstream and downstream both offering a handshake.
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_pkts", pkts_sent, 0);
    check("rst_trains", trains_sent, 0);
    reset_n  = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    step();

    // Two trains of three packets, pkt gap 4, train gap 10.
    clear_mon();
    base = rx_q.size();
    d0   = done_cnt;
    pulse_start(3, 2, 4, 10);
    send_pkts(6, 3, 1'b0);
    @(negedge clk);
    check("t1_done_pulse", done, 1);
    check("t1_busy_fall", busy, 0);
    check("t1_pkts", pkts_sent, 6);
    check("t1_trains", trains_sent, 2);
    check("t1_first_latency", rx_cyc_q[base] - start_cyc, 1);
    check("t1_gap_count", gap_q.size(), 5);
    for (int i = 0; i < 5 && i < gap_q.size(); i++)
      check($sformatf("t1_gap%0d", i), gap_q[i], (i == 2) ? 10 : 4);
    step();
    @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_done_low", done, 0);

    // Endless run with zero gaps, then a stop between packets.
    clear_mon();
    d0 = done_cnt;
    pulse_start(3, 0, 0, 0);
    send_pkts(20, 2, 1'b0);
    @(negedge clk);
    check("t2_busy", busy, 1);
    check("t2_pkts", pkts_sent, 20);
    check("t2_trains", trains_sent, 6);
    check("t2_no_done", done_cnt - d0, 0);
    check("t2_gap_count", gap_q.size(), 19);
    bad = 0;
    foreach (gap_q[i]) if (gap_q[i] != 0) bad++;
    check("t2_gaps_zero", bad, 0);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("t2_stop_done", done, 1);
    check("t2_stop_busy", busy, 0);
    step();

    // Stop during beat 2 of a 5-beat packet drains the rest, then holds the next packet.
    base = rx_q.size();
    pulse_start(4, 0, 0, 0);
    send_pkt(5, 1, 1'b0);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = 64'(seq);
    @(negedge clk);
    check("t3_done_pulse", done, 1);
    check("t3_busy", busy, 0);
    check("t3_beats", rx_q.size() - base, 5);
    check("t3_pkts", pkts_sent, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (s_tready || m_tvalid) bad++;
      step();
      @(negedge clk);
    end
    check("t3_held", bad, 0);
    s_tvalid = 1'b0;
    step();

    // Random downstream backpressure: data intact, gaps measured from end beats.
    clear_mon();
    base = rx_q.size();
    d0   = seq;
    pulse_start(2, 2, 3, 5);
    send_pkts(4, 4, 1'b1);
    @(negedge clk);
    check("t4_done_pulse", done, 1);
    check("t4_pkts", pkts_sent, 4);
    check("t4_trains", trains_sent, 2);
    check("t4_beats", rx_q.size() - base, 16);
    bad = 0;
    for (int i = 0; i < 16 && base + i < rx_q.size(); i++)
      if (rx_q[base + i] != 64'(d0 + i)) bad++;
    check("t4_data_order", bad, 0);
    check("t4_gap_count", gap_q.size(), 3);
    for (int i = 0; i < 3 && i < gap_q.size(); i++)
      check($sformatf("t4_gap%0d", i), gap_q[i], (i == 1) ? 5 : 3);
    step();

    // Reset during a train gap.
    pulse_start(1, 0, 0, 20);
    send_pkts(1, 2, 1'b0);
    @(negedge clk);
    check("t5_in_gap_trains", trains_sent, 1);
    check("t5_in_gap_busy", busy, 1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("t5_rst_gap_busy", busy, 0);
    check("t5_rst_gap_pkts", pkts_sent, 0);
    check("t5_rst_gap_trains", trains_sent, 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Reset in the middle of a packet.
    pulse_start(1, 0, 0, 0);
    send_pkts(1, 2, 1'b0);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = 64'(seq);
    @(negedge clk);
    check("t5_mid_pkt_valid", m_tvalid, 1);
    step();
    reset_n = 1'b0;
    #1;
    check("t5_rst_pkt_m_tvalid", m_tvalid, 0);
    check("t5_rst_pkt_s_tready", s_tready, 0);
    check("t5_rst_pkt_busy", busy, 0);
    check("t5_rst_pkt_pkts", pkts_sent, 0);
    s_tvalid = 1'b0;
    seq++;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Fresh run after reset.
    base = rx_q.size();
    pulse_start(1, 1, 0, 0);
    send_pkts(1, 3, 1'b0);
    @(negedge clk);
    check("t5_fresh_done", done, 1);
    check("t5_fresh_pkts", pkts_sent, 1);
    check("t5_fresh_trains", trains_sent, 1);
    check("t5_fresh_latency", rx_cyc_q[base] - start_cyc, 1);
    step();

    // start and cfg changes mid-run are ignored.
    clear_mon();
    pulse_start(2, 1, 2, 0);
    send_pkt(2, -1, 1'b0);
    cfg_train_len  = 16'd5;
    cfg_num_trains = 16'd3;
    cfg_pkt_gap    = 32'd0;
    start          = 1'b1;
    send_pkt(2, -1, 1'b0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    check("t6_done_pulse", done, 1);
    check("t6_pkts", pkts_sent, 2);
    check("t6_trains", trains_sent, 1);
    check("t6_gap_count", gap_q.size(), 1);
    if (gap_q.size() > 0) check("t6_gap", gap_q[0], 2);
    step();

    // stop in IDLE is ignored.
    d0   = done_cnt;
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("t6_idle_stop_done", done, 0);
    check("t6_idle_stop_busy", busy, 0);
    step();

    // stop during a packet gap ends the run on the next cycle.
    pulse_start(2, 0, 8, 0);
    send_pkts(1, 2, 1'b0);
    step();
    step();
    @(negedge clk);
    check("t6_gap_busy", busy, 1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("t6_gap_stop_done", done, 1);
    check("t6_gap_stop_busy", busy, 0);
    check("t6_gap_stop_pkts", pkts_sent, 1);
    step();
    @(negedge clk);
    check("t6_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
